// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared states, parity modes and frame helpers for the framed SerDes
package serdes_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    localparam int MAX_DATA_W  = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

    function automatic int frame_len(input int data_w, input int mode);
        return data_w + 2 + ((mode != PARITY_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/serdes_rx_deframer.sv
// rtl/serdes_rx_deframer.sv - RX frame FSM, word assembly and error flags
module serdes_rx_deframer
    import serdes_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int MSB_FIRST   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              ser_bit,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_par_err,
    output logic              rx_frm_err
);

    localparam int CW = $clog2(frame_len(DATA_W, PARITY_MODE));
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              valid_q, valid_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;

    assign rx_data    = rx_data_q;
    assign rx_valid   = valid_q;
    assign rx_par_err = par_err_q;
    assign rx_frm_err = frm_err_q;

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        case (state_q)
            RX_IDLE: if (bit_en && !ser_bit) begin
                cnt_d   = '0;
                state_d = RX_DATA;
            end
            RX_DATA: if (bit_en) begin
                asm_d = (MSB_FIRST != 0) ? {asm_q[DATA_W-2:0], ser_bit}
                                         : {ser_bit, asm_q[DATA_W-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT)
                    state_d = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (bit_en) begin
                par_d   = ser_bit;
                state_d = RX_STOP;
            end
            RX_STOP: if (bit_en) begin
                rx_data_d = asm_q;
                valid_d   = 1'b1;
                par_err_d = (PARITY_MODE != PARITY_NONE) &&
                            (par_q != parity_bit(MAX_DATA_W'(asm_q), PARITY_MODE));
                frm_err_d = !ser_bit;
                // A low stop bit means the line may be held in break; wait for it to rise
                state_d   = ser_bit ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: if (bit_en && ser_bit) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            asm_q     <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

endmodule

// File: rtl/serdes_frame_xcvr.sv
// rtl/serdes_frame_xcvr.sv - framed serializer/deserializer with loopback and break handling
module serdes_frame_xcvr
    import serdes_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int MSB_FIRST   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              loopback,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    input  logic              ser_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_par_err,
    output logic              rx_frm_err
);

    localparam int CW = $clog2(frame_len(DATA_W, PARITY_MODE));
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic              tx_par_q, tx_par_d;
    logic              ser_out_q, ser_out_d;
    logic              gap_ok_q, gap_ok_d;
    logic              ser_in_q, ser_in_d;

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign ser_out  = ser_out_q;
    assign ser_in_d = loopback ? ser_out_q : ser_in;

    // gap_ok records that a full bit period has elapsed since the last stop bit began,
    // so back-to-back frames always see at least two stop periods even with sparse bit_en.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_par_d   = tx_par_q;
        ser_out_d  = ser_out_q;
        gap_ok_d   = gap_ok_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (bit_en) gap_ok_d = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = parity_bit(MAX_DATA_W'(tx_data), PARITY_MODE);
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (bit_en) begin
                if (gap_ok_q) begin
                    ser_out_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    gap_ok_d = 1'b1;
                end
            end
            TX_DATA: if (bit_en) begin
                if (MSB_FIRST != 0) begin
                    ser_out_d  = tx_shift_q[DATA_W-1];
                    tx_shift_d = tx_shift_q << 1;
                end else begin
                    ser_out_d  = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_cnt_q == LAST_BIT)
                    tx_state_d = (PARITY_MODE != PARITY_NONE) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (bit_en) begin
                ser_out_d  = tx_par_q;
                tx_state_d = TX_STOP;
            end
            TX_STOP: if (bit_en) begin
                ser_out_d  = 1'b1;
                gap_ok_d   = 1'b0;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_par_q   <= 1'b0;
            ser_out_q  <= 1'b1;
            gap_ok_q   <= 1'b1;
            ser_in_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_par_q   <= tx_par_d;
            ser_out_q  <= ser_out_d;
            gap_ok_q   <= gap_ok_d;
            ser_in_q   <= ser_in_d;
        end
    end

    serdes_rx_deframer #(
        .DATA_W      (DATA_W),
        .PARITY_MODE (PARITY_MODE),
        .MSB_FIRST   (MSB_FIRST)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .ser_bit    (ser_in_q),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err)
    );

endmodule

// File: tb/tb_serdes_frame_xcvr.sv
// tb/tb_serdes_frame_xcvr.sv - scoreboard bench for serdes_frame_xcvr
module tb_serdes_frame_xcvr;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       frm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, bit_en, loopback, ser_in;
    logic [7:0] a_tx_data, b_tx_data;
    logic       a_tx_valid, b_tx_valid;
    logic       a_tx_ready, a_ser_out, a_rx_valid, a_rx_par_err, a_rx_frm_err;
    logic       b_tx_ready, b_ser_out, b_rx_valid, b_rx_par_err, b_rx_frm_err;
    logic [7:0] a_rx_data, b_rx_data;

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic sparse_mode = 1'b0;
    logic sparse_chk  = 1'b0;
    logic last_en     = 1'b1;
    logic prev_ser    = 1'b1;

    serdes_frame_xcvr u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .loopback   (loopback),
        .tx_data    (a_tx_data),
        .tx_valid   (a_tx_valid),
        .tx_ready   (a_tx_ready),
        .ser_out    (a_ser_out),
        .ser_in     (ser_in),
        .rx_data    (a_rx_data),
        .rx_valid   (a_rx_valid),
        .rx_par_err (a_rx_par_err),
        .rx_frm_err (a_rx_frm_err)
    );

    serdes_frame_xcvr #(.DATA_W(8), .PARITY_MODE(2), .MSB_FIRST(1)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .loopback   (1'b1),
        .tx_data    (b_tx_data),
        .tx_valid   (b_tx_valid),
        .tx_ready   (b_tx_ready),
        .ser_out    (b_ser_out),
        .ser_in     (1'b1),
        .rx_data    (b_rx_data),
        .rx_valid   (b_rx_valid),
        .rx_par_err (b_rx_par_err),
        .rx_frm_err (b_rx_frm_err)
    );

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.par  = p;
        e.frm  = f;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : gen_bit_en
        int ph;
        ph = 0;
        bit_en = 1'b1;
        forever begin
            @(negedge clk);
            if (sparse_mode) begin
                bit_en = (ph == 0);
                ph = (ph + 1) % 4;
            end else begin
                bit_en = 1'b1;
                ph = 0;
            end
        end
    end

    always @(posedge clk) last_en <= bit_en;

    always @(negedge clk) begin
        if (sparse_chk && (a_ser_out !== prev_ser)) begin
            checks++;
            if (!last_en) begin
                errors++;
                $display("FAIL ser_out_change_without_bit_en: got change to %0b expected no change", a_ser_out);
            end
        end
        prev_ser = a_ser_out;
    end

    always @(negedge clk) begin
        if (a_rx_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rx_valid: got rx_data %0h frm %0b expected no frame", a_rx_data, a_rx_frm_err);
            end else begin
                ea = q_a.pop_front();
                check("a_rx_data", a_rx_data, ea.data);
                check("a_rx_par_err", a_rx_par_err, ea.par);
                check("a_rx_frm_err", a_rx_frm_err, ea.frm);
            end
        end
        if (b_rx_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rx_valid: got rx_data %0h expected no frame", b_rx_data);
            end else begin
                eb = q_b.pop_front();
                check("b_rx_data", b_rx_data, eb.data);
                check("b_rx_par_err", b_rx_par_err, eb.par);
                check("b_rx_frm_err", b_rx_frm_err, eb.frm);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge, tx_valid still high.
    task automatic offer(input bit use_b, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        if (use_b) begin
            b_tx_data = d; b_tx_valid = 1'b1;
        end else begin
            a_tx_data = d; a_tx_valid = 1'b1;
        end
        for (int i = 0; i < 400; i++) begin
            if (use_b ? b_tx_ready : a_tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL offer_timeout: got tx_ready 0 expected 1 for word %0h", d);
        end
        @(negedge clk);
    endtask

    task automatic check_seq(input string name, input logic [10:0] seq, input bit use_b);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check($sformatf("%s_bit%0d", name, i), use_b ? b_ser_out : a_ser_out, seq[10-i]);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d frames pending expected 0", name, q_a.size() + q_b.size());
        end
    endtask

    task automatic drive_frame(input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            ser_in = bits[10-i];
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; loopback = 1'b1; ser_in = 1'b1;
        a_tx_data = 8'h00; a_tx_valid = 1'b0;
        b_tx_data = 8'h00; b_tx_valid = 1'b0;
        @(negedge clk);
        check("rst_ser_out", a_ser_out, 1);
        check("rst_tx_ready", a_tx_ready, 1);
        check("rst_rx_data", a_rx_data, 0);
        check("rst_rx_valid", a_rx_valid, 0);
        check("rst_par_err", a_rx_par_err, 0);
        check("rst_frm_err", a_rx_frm_err, 0);
        check("rst_b_ser_out", b_ser_out, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
        offer(1'b0, 8'hA5);
        a_tx_valid = 1'b0;
        check("t1_tx_busy", a_tx_ready, 0);
        check_seq("t1_ser", 11'b0_10100101_0_1, 1'b0);
        drain("t1");

        q_b.push_back(mk(8'h3C, 1'b0, 1'b0));
        offer(1'b1, 8'h3C);
        b_tx_valid = 1'b0;
        check_seq("t2_ser", 11'b0_00111100_1_1, 1'b1);
        drain("t2");

        loopback = 1'b0;
        q_a.push_back(mk(8'h0F, 1'b1, 1'b0));
        drive_frame(11'b0_11110000_1_1);
        ser_in = 1'b1;
        drain("t3");

        q_a.push_back(mk(8'h00, 1'b0, 1'b1));
        drive_frame(11'b0_00000000_0_0);
        ser_in = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_break_frames_pending", q_a.size(), 0);
        ser_in = 1'b1;
        repeat (3) @(negedge clk);
        q_a.push_back(mk(8'h55, 1'b0, 1'b0));
        drive_frame(11'b0_10101010_0_1);
        ser_in = 1'b1;
        drain("t4");

        loopback = 1'b1;
        sparse_mode = 1'b1;
        sparse_chk = 1'b1;
        q_a.push_back(mk(8'h81, 1'b0, 1'b0));
        q_a.push_back(mk(8'h7E, 1'b0, 1'b0));
        offer(1'b0, 8'h81);
        check("t5_busy_81", a_tx_ready, 0);
        a_tx_data = 8'h7E;
        repeat (30) @(negedge clk);
        check("t5_busy_mid_81", a_tx_ready, 0);
        offer(1'b0, 8'h7E);
        check("t5_busy_7e", a_tx_ready, 0);
        repeat (30) @(negedge clk);
        check("t5_busy_mid_7e", a_tx_ready, 0);
        a_tx_valid = 1'b0;
        drain("t5");
        sparse_chk = 1'b0;
        sparse_mode = 1'b0;
        repeat (8) @(negedge clk);

        offer(1'b0, 8'h00);
        a_tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_bit3_before_reset", a_ser_out, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ser_out", a_ser_out, 1);
        check("t6_rst_tx_ready", a_tx_ready, 1);
        check("t6_rst_rx_valid", a_rx_valid, 0);
        check("t6_rst_rx_data", a_rx_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_ser_out", a_ser_out, 1);
        q_a.push_back(mk(8'hC3, 1'b0, 1'b0));
        offer(1'b0, 8'hC3);
        a_tx_valid = 1'b0;
        check_seq("t6_ser", 11'b0_11000011_0_1, 1'b0);
        drain("t6");
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
